regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined MIPS32 core and its dual-issue successor. It provides NRD registered read ports and NWR write ports. Register 0 is hardwired to zero. After reset, a hardware sweep initialises every entry, including the stack-pointer preload, and a busy flag holds the pipeline until the sweep completes. It sits in the decode stage; the writeback stage drives its write ports.

---
 rtl/regfile_pkg.sv | 34 +++
 rtl/regfile_wr_arb.sv | 30 +++
 rtl/regfile_mp.sv | 96 +++++++++
 tb/tb_regfile_mp.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, MIPS register names and the init/run state encoding for regfile_mp.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  localparam int REG_ZERO = 0;
  localparam int REG_AT   = 1;
  localparam int REG_V0   = 2;
  localparam int REG_V1   = 3;
  localparam int REG_A0   = 4;
  localparam int REG_A1   = 5;
  localparam int REG_A2   = 6;
  localparam int REG_A3   = 7;
  localparam int REG_T0   = 8;
  localparam int REG_T7   = 15;
  localparam int REG_S0   = 16;
  localparam int REG_S7   = 23;
  localparam int REG_T8   = 24;
  localparam int REG_T9   = 25;
  localparam int REG_K0   = 26;
  localparam int REG_K1   = 27;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_FP   = 30;
  localparam int REG_RA   = 31;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// Folds NWR write ports into per-entry enables/data; higher port wins, address 0 masked.
// Purely combinational, no flow control.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NWR    = 2
) (
  input  logic                                  en,
  input  logic [NWR-1:0]                        we,
  input  logic [NWR*ADDR_W-1:0]                 wa,
  input  logic [NWR*DATA_W-1:0]                 wd,
  output logic [2**ADDR_W-1:0]                  ent_we,
  output logic [2**ADDR_W-1:0][DATA_W-1:0]      ent_wd
);

  always_comb begin
    ent_we = '0;
    ent_wd = '0;
    // Ascending port order: a later port overwrites an earlier one on the same entry.
    for (int k = 0; k < NWR; k++) begin
      if (en && we[k] && (wa[k*ADDR_W +: ADDR_W] != '0)) begin
        ent_we[wa[k*ADDR_W +: ADDR_W]] = 1'b1;
        ent_wd[wa[k*ADDR_W +: ADDR_W]] = wd[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardware init sweep; 1-cycle registered-address reads, write-first.
// No backpressure: busy holds the pipeline off during the 2**ADDR_W-cycle sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                NRD     = 3,
  parameter int                NWR     = 2,
  parameter int                SP_IDX  = REG_SP,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h100)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NWR*DATA_W-1:0] wd,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  input  logic [ADDR_W-1:0]     dbg_sel,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t                        state;
  logic [ADDR_W-1:0]             idx;
  logic [DATA_W-1:0]             rf [DEPTH];
  logic [ADDR_W-1:0]             raddr [NRD];
  logic [DEPTH-1:0]              ent_we;
  logic [DEPTH-1:0][DATA_W-1:0]  ent_wd;
  logic                          wr_en;
  logic                          sweep_en;

  // A reset cycle in RUN must not commit the write presented alongside it.
  assign wr_en    = (state == RUN) && !rst;
  assign sweep_en = (state == INIT) && !rst;

  regfile_wr_arb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NWR    (NWR)
  ) u_wr_arb (
    .en     (wr_en),
    .we     (we),
    .wa     (wa),
    .wd     (wd),
    .ent_we (ent_we),
    .ent_wd (ent_wd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      idx   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          idx <= idx + ADDR_W'(1);
          if (idx == '1) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_en) begin
      rf[idx] <= (idx == ADDR_W'(SP_IDX)) ? SP_INIT : '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_we[e]) rf[e] <= ent_wd[e];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NRD; j++) begin
      if (rst) raddr[j] <= '0;
      else     raddr[j] <= ra[j*ADDR_W +: ADDR_W];
    end
  end

  // Reads come from the registered address and the live array, so same-edge writes show through.
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    assign rd[j*DATA_W +: DATA_W] = (busy || (raddr[j] == '0)) ? '0 : rf[raddr[j]];
  end

  assign dbg_data = (dbg_sel == '0) ? '0 : rf[dbg_sel];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expected read data queued at issue, compared after the edge.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int DEPTH = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                busy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*DW-1:0]   wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*DW-1:0]   rd;
  logic [AW-1:0]       dbg_sel;
  logic [DW-1:0]       dbg_data;

  typedef struct {
    int          port;
    int          addr;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [31:0] model [DEPTH];
  int          errors = 0;
  int          checks = 0;

  regfile_mp #(
    .DATA_W (DW), .ADDR_W (AW), .NRD (NRD), .NWR (NWR),
    .SP_IDX (29), .SP_INIT (32'h100)
  ) dut (
    .clk (clk), .rst (rst), .busy (busy),
    .we (we), .wa (wa), .wd (wd),
    .ra (ra), .rd (rd),
    .dbg_sel (dbg_sel), .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    model[29] = 32'h100;
  endtask

  task automatic set_write(int k, int a, logic [31:0] d, bit live);
    we[k] = 1'b1;
    wa[k*AW +: AW] = AW'(a);
    wd[k*DW +: DW] = d;
    if (live && a != 0) model[a] = d;
  endtask

  task automatic issue_read(int j, int a);
    ra[j*AW +: AW] = AW'(a);
    sb.push_back('{port: j, addr: a, exp: (a == 0) ? 32'h0 : model[a]});
  endtask

  task automatic test_reset();
    int  cnt;
    bit  rd_seen;
    we = '0; wa = '0; wd = '0; ra = '0; dbg_sel = '0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++;
    if (rd !== '0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd); end
    for (int j = 0; j < NRD; j++) ra[j*AW +: AW] = AW'(29);
    rst = 1'b0;
    cnt = 0;
    rd_seen = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      if (rd !== '0) rd_seen = 1'b1;
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 32) begin errors++; $display("FAIL sweep_len: got %0d cycles want 32", cnt); end
    checks++;
    if (rd_seen) begin errors++; $display("FAIL sweep_rd_zero: got nonzero rd want 0"); end
    model_reset();
    dbg_sel = AW'(29);
    #1;
    checks++;
    if (dbg_data !== 32'h100) begin errors++; $display("FAIL sweep_sp: got %h want 00000100", dbg_data); end
    dbg_sel = AW'(5);
    #1;
    checks++;
    if (dbg_data !== 32'h0) begin errors++; $display("FAIL sweep_r5: got %h want 0", dbg_data); end
    ra = '0;
  endtask

  task automatic test_basic();
    rd_exp_t     e;
    logic [31:0] got;
    set_write(0, 8, 32'hDEADBEEF, 1'b1);
    tick();
    we = '0;
    issue_read(0, 8);
    tick();
    set_write(0, 0, 32'h1234, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = rd[e.port*DW +: DW];
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL basic rd%0d a%0d: got %h want %h", e.port, e.addr, got, e.exp); end
    end
    tick();
    we = '0;
    issue_read(0, 0);
    dbg_sel = '0;
    #1;
    checks++;
    if (dbg_data !== 32'h0) begin errors++; $display("FAIL dbg_zero: got %h want 0", dbg_data); end
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = rd[e.port*DW +: DW];
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL zero_reg rd%0d a%0d: got %h want %h", e.port, e.addr, got, e.exp); end
    end
  endtask

  task automatic test_same_cycle();
    rd_exp_t     e;
    logic [31:0] got;
    set_write(0, 17, 32'hA5A5A5A5, 1'b1);
    issue_read(1, 17);
    tick();
    we = '0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = rd[e.port*DW +: DW];
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL write_first rd%0d a%0d: got %h want %h", e.port, e.addr, got, e.exp); end
    end
  endtask

  task automatic test_conflict();
    rd_exp_t     e;
    logic [31:0] got;
    set_write(0, 12, 32'h11, 1'b1);
    set_write(1, 12, 32'h22, 1'b1);
    tick();
    set_write(0, 20, 32'hAAAA0001, 1'b1);
    set_write(1, 21, 32'hBBBB0002, 1'b1);
    issue_read(0, 12);
    tick();
    we = '0;
    issue_read(0, 20);
    issue_read(2, 21);
    issue_read(1, 12);
    while (sb.size() > 3) begin
      e = sb.pop_front();
      got = rd[e.port*DW +: DW];
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL conflict rd%0d a%0d: got %h want %h", e.port, e.addr, got, e.exp); end
    end
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = rd[e.port*DW +: DW];
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL dual_write rd%0d a%0d: got %h want %h", e.port, e.addr, got, e.exp); end
    end
  endtask

  task automatic test_back_to_back();
    rd_exp_t     e;
    logic [31:0] got;
    int          prev;
    we = '0;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      int a;
      a = 1 + i * 3;
      set_write(1, a, $urandom, 1'b1);
      issue_read(0, a);
      issue_read(1, prev);
      issue_read(2, 29);
      prev = a;
      tick();
      while (sb.size() != 0) begin
        e = sb.pop_front();
        got = rd[e.port*DW +: DW];
        checks++;
        if (got !== e.exp) begin errors++; $display("FAIL b2b rd%0d a%0d: got %h want %h", e.port, e.addr, got, e.exp); end
      end
    end
    we = '0;
  endtask

  task automatic test_reset_mid_sweep();
    rd_exp_t     e;
    logic [31:0] got;
    int          cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_sweep_busy: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_write(0, 3, 32'hFF, 1'b0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    we = '0;
    checks++;
    if (cnt != 32) begin errors++; $display("FAIL restart_len: got %0d cycles want 32", cnt); end
    model_reset();
    dbg_sel = AW'(3);
    #1;
    checks++;
    if (dbg_data !== 32'h0) begin errors++; $display("FAIL busy_write_dbg: got %h want 0", dbg_data); end
    issue_read(0, 3);
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = rd[e.port*DW +: DW];
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL busy_write rd%0d a%0d: got %h want %h", e.port, e.addr, got, e.exp); end
    end
  endtask

  task automatic test_reset_in_run();
    rd_exp_t     e;
    logic [31:0] got;
    int          cnt;
    set_write(0, 29, 32'h500, 1'b1);
    tick();
    we = '0;
    dbg_sel = AW'(29);
    #1;
    checks++;
    if (dbg_data !== 32'h500) begin errors++; $display("FAIL sp_load: got %h want 00000500", dbg_data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 32) begin errors++; $display("FAIL run_reset_len: got %0d cycles want 32", cnt); end
    model_reset();
    issue_read(2, 29);
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = rd[e.port*DW +: DW];
      checks++;
      if (got !== e.exp) begin errors++; $display("FAIL sp_reinit rd%0d a%0d: got %h want %h", e.port, e.addr, got, e.exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_conflict();
    test_back_to_back();
    test_reset_mid_sweep();
    test_reset_in_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
